// File: rtl/daq_src_arbiter.sv
// daq_src_arbiter
// Round-robin arbiter that shares one daq input slot (req/grant/data/valid/end)
// among NSRC producers. The granted source's words are forwarded through a
// single register stage. A per-packet watchdog forces a terminating abort word
// when a packet stalls for TIMEOUT cycles or its requester goes away, so the
// daq slot can never be held forever.
//
// Optional feature macro: DAQ_ARB_PRIO0_EN
//   defined   : source 0 wins every arbitration in which it requests, and the
//               round-robin pointer only advances after grants to sources
//               1..NSRC-1 (high-rate signal capture path).
//   undefined : pure round robin.

module daq_src_arbiter #(
  parameter int          NSRC       = 4,
  parameter int          TIMEOUT    = 4096,
  parameter int          TO_BITS    = 13,
  parameter logic [31:0] ABORT_WORD = 32'hdead0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [32*NSRC-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC-1:0]      src_end,
  input  logic [NSRC-1:0]      src_req,
  output logic [NSRC-1:0]      src_grant,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  output logic                 out_end,
  output logic                 out_req,
  input  logic                 out_grant,
  output logic [NSRC-1:0]      abort_err,
  input  logic                 abort_clr
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  state_t             state_r;
  state_t             state_nxt;
  logic [PTR_W-1:0]   winner_r;
  logic [PTR_W-1:0]   winner_nxt;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [TO_BITS-1:0] wdog_r;
  logic [TO_BITS-1:0] wdog_nxt;

  logic [NSRC-1:0]    grant_nxt;
  logic [31:0]        data_nxt;
  logic               valid_nxt;
  logic               end_nxt;
  logic               req_nxt;
  logic [NSRC-1:0]    abort_set;
  logic [NSRC-1:0]    abort_nxt;

  // Winner-side views of the source bus
  logic [31:0]        sel_data;
  logic               sel_valid;
  logic               sel_end;
  logic               sel_req;
  logic [NSRC-1:0]    win_onehot;
  logic [31:0]        abort_word;
  logic [PTR_W-1:0]   ptr_after_win;
  logic               wdog_expired;

  // ---------------------------------------------------------------------------
  // Arbitration helper: first requester at or after ptr, wrapping at NSRC.
  // With the priority feature enabled, source 0 overrides the rotation.
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] pick_next(
    input logic [NSRC-1:0]  req,
    input logic [PTR_W-1:0] ptr
  );
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx_w;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx   = (int'(ptr) + k) % NSRC;
      idx_w = PTR_W'(idx);
      if (!found && req[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
`ifdef DAQ_ARB_PRIO0_EN
    if (req[0]) begin
      pick = {PTR_W{1'b0}};
    end else begin
      pick = pick;
    end
`endif
    return pick;
  endfunction

  // Index following the winner, wrapping to 0 after the last source.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] w);
    logic [PTR_W-1:0] r;
    if (w == PTR_W'(NSRC - 1)) begin
      r = {PTR_W{1'b0}};
    end else begin
      r = w + PTR_W'(1);
    end
    return r;
  endfunction

  // Mux the latched winner's channel out of the flattened source bus.
  always_comb begin
    sel_data   = 32'h0000_0000;
    sel_valid  = 1'b0;
    sel_end    = 1'b0;
    sel_req    = 1'b0;
    win_onehot = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      win_onehot[i] = (winner_r == PTR_W'(i));
      sel_data      = win_onehot[i] ? src_data[32*i +: 32] : sel_data;
      sel_valid     = win_onehot[i] ? src_valid[i]         : sel_valid;
      sel_end       = win_onehot[i] ? src_end[i]           : sel_end;
      sel_req       = win_onehot[i] ? src_req[i]           : sel_req;
    end
  end

  // Abort word tags the offending source in the low bits; pointer successor.
  always_comb begin
    abort_word    = ABORT_WORD | {{(32-PTR_W){1'b0}}, winner_r};
    ptr_after_win = wrap_inc(winner_r);
    wdog_expired  = (wdog_r == TO_BITS'(TIMEOUT - 1));
  end

  // Next-state, datapath and flag logic for the IDLE/WAIT/XFER/DONE sequence.
  always_comb begin
    state_nxt  = state_r;
    winner_nxt = winner_r;
    ptr_nxt    = ptr_r;
    wdog_nxt   = wdog_r;
    grant_nxt  = src_grant;
    data_nxt   = out_data;
    valid_nxt  = 1'b0;
    end_nxt    = 1'b0;
    req_nxt    = out_req;
    abort_set  = {NSRC{1'b0}};

    case (state_r)
      ST_IDLE: begin
        grant_nxt = {NSRC{1'b0}};
        if (|src_req) begin
          winner_nxt = pick_next(src_req, ptr_r);
          req_nxt    = 1'b1;
          state_nxt  = ST_WAIT;
        end else begin
          req_nxt    = 1'b0;
        end
      end

      ST_WAIT: begin
        // Winner is frozen here; the watchdog starts only once granted.
        if (out_grant) begin
          grant_nxt = win_onehot;
          wdog_nxt  = {TO_BITS{1'b0}};
          state_nxt = ST_XFER;
        end else begin
          grant_nxt = {NSRC{1'b0}};
        end
      end

      ST_XFER: begin
        if (!sel_req) begin
          // Requester abandoned the packet (including zero-length packets).
          data_nxt  = abort_word;
          valid_nxt = 1'b1;
          end_nxt   = 1'b1;
          abort_set = win_onehot;
          grant_nxt = {NSRC{1'b0}};
          state_nxt = ST_DONE;
        end else if (sel_valid) begin
          // A valid word always wins over watchdog expiry in the same cycle.
          data_nxt  = sel_data;
          valid_nxt = 1'b1;
          end_nxt   = sel_end;
          wdog_nxt  = {TO_BITS{1'b0}};
          if (sel_end) begin
            grant_nxt = {NSRC{1'b0}};
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_XFER;
          end
        end else if (wdog_expired) begin
          data_nxt  = abort_word;
          valid_nxt = 1'b1;
          end_nxt   = 1'b1;
          abort_set = win_onehot;
          grant_nxt = {NSRC{1'b0}};
          state_nxt = ST_DONE;
        end else begin
          data_nxt  = sel_data;
          wdog_nxt  = wdog_r + TO_BITS'(1);
        end
      end

      ST_DONE: begin
        // Dropping out_req here and re-raising no earlier than IDLE leaves
        // at least one low cycle between packets.
        req_nxt   = 1'b0;
        grant_nxt = {NSRC{1'b0}};
`ifdef DAQ_ARB_PRIO0_EN
        if (winner_r != {PTR_W{1'b0}}) begin
          ptr_nxt = ptr_after_win;
        end else begin
          ptr_nxt = ptr_r;
        end
`else
        ptr_nxt   = ptr_after_win;
`endif
        state_nxt = ST_IDLE;
      end

      default: begin
        req_nxt   = 1'b0;
        grant_nxt = {NSRC{1'b0}};
        state_nxt = ST_IDLE;
      end
    endcase

    // A new abort beats a simultaneous clear.
    abort_nxt = (abort_err & ~{NSRC{abort_clr}}) | abort_set;
  end

  // State register plus all registered outputs, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      winner_r  <= {PTR_W{1'b0}};
      ptr_r     <= {PTR_W{1'b0}};
      wdog_r    <= {TO_BITS{1'b0}};
      src_grant <= {NSRC{1'b0}};
      out_data  <= 32'h0000_0000;
      out_valid <= 1'b0;
      out_end   <= 1'b0;
      out_req   <= 1'b0;
      abort_err <= {NSRC{1'b0}};
    end else begin
      state_r   <= state_nxt;
      winner_r  <= winner_nxt;
      ptr_r     <= ptr_nxt;
      wdog_r    <= wdog_nxt;
      src_grant <= grant_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_end   <= end_nxt;
      out_req   <= req_nxt;
      abort_err <= abort_nxt;
    end
  end

endmodule

// File: doc/daq_src_arbiter.md
Name: daq_src_arbiter

Overview:
- Round-robin arbiter placed ahead of one daq input slot.
- Shares that single req/grant/data/valid/end channel among NSRC producers (signal capture, stepper trace, etc.).
- Forwards each granted source's packet through one register stage.
- A per-packet watchdog terminates stalled or abandoned packets so the daq input slot is never locked.

Parameters:
NSRC, 4, number of upstream sources (2..8)
TIMEOUT, 4096, max idle cycles inside a packet before forced termination
TO_BITS, 13, watchdog counter width; must satisfy 2^TO_BITS > TIMEOUT
ABORT_WORD, 32'hdead0000, base word emitted on forced termination; source index is OR'd into bits [3:0]

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
src_data  in  32*NSRC  flattened source data; source i occupies [32*i+31:32*i]
src_valid  in  NSRC  per-source word valid
src_end  in  NSRC  per-source last-word flag, qualified by src_valid
src_req  in  NSRC  per-source packet request
src_grant  out  NSRC  one-hot grant
out_data  out  32  registered data to the daq slot
out_valid  out  1  registered valid
out_end  out  1  registered end
out_req  out  1  request to the daq slot
out_grant  in  1  grant from the daq slot
abort_err  out  NSRC  sticky per-source abort flags
abort_clr  in  1  clears all abort_err bits

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values: src_grant=0, out_data=0, out_valid=0, out_end=0, out_req=0, abort_err=0, round-robin pointer=0, state=IDLE.
- IDLE:
  - If any src_req is high, latch winner = first requesting index at or after the pointer, wrapping modulo NSRC.
  - Set out_req=1 and go to WAIT.
- WAIT:
  - Hold out_req until out_grant=1.
  - Next cycle: src_grant[winner]=1, go to XFER.
  - The winner is not re-evaluated in WAIT.
- XFER, forwarding:
  - Each cycle, out_valid<=src_valid[winner], out_data<=winner's data, out_end<=src_end[winner]&src_valid[winner].
  - Latency is exactly 1 cycle from source to output.
  - Watchdog clears on every valid word and increments otherwise.
- XFER, normal exit:
  - On a valid word with end=1: drop src_grant the same edge, go to DONE.
- XFER, forced termination (data is forwarded only while src_req[winner]=1):
  - Triggers when the watchdog reaches TIMEOUT, or when src_req[winner] drops without an end word.
  - Emit one word: out_data=ABORT_WORD|winner, out_valid=1, out_end=1.
  - Set abort_err[winner], drop src_grant, go to DONE.
- DONE:
  - out_req<=0.
  - Pointer<=winner+1, wrapping to 0 at NSRC.
  - Return to IDLE; a new out_req is raised no earlier than the following cycle, guaranteeing one low cycle between packets.
- Simultaneous events:
  - A valid end word and a watchdog expiry in the same cycle resolve as a normal end, with no abort.
  - abort_clr and a new abort in the same cycle leave the bit set.
- out_grant dropping during XFER: the packet continues. The daq block never revokes a grant mid-packet; this is out of scope.
- Reset mid-packet: all outputs return to reset values asynchronously. There is no partial-packet recovery; the downstream daq must also be in reset.
- A zero-length packet (req dropped before any word) counts as an abort.

Optional Feature:
- Macro: DAQ_ARB_PRIO0_EN.
- Defined:
  - Source 0 wins every IDLE arbitration in which it requests, regardless of the pointer.
  - The pointer advances only after grants to sources 1..NSRC-1.
  - Intended for the high-rate signal capture path.
- Undefined: pure round robin as described above.

Test Plan:
- Single source 2 sends 3 words 0x11,0x22,0x33 (end on 0x33), out_grant tied high.
  - out_valid follows with 1-cycle latency, carrying the same words and out_end on 0x33.
  - src_grant=4'b0100 for those cycles; out_req drops 1 cycle after end.
- Sources 0,1,3 request simultaneously with pointer=0.
  - Grant order is 0,1,3, then 0 again if it re-requests.
  - There is at least one out_req-low cycle between packets.
- Source 1 granted, sends 1 word, then idles with TIMEOUT=16.
  - After 16 idle cycles: out_data=0xdead0001, out_valid=1, out_end=1.
  - abort_err=4'b0010.
  - abort_clr pulse returns abort_err to 0.
- Source 3 drops src_req after 2 words without end.
  - The next cycle emits 0xdead0003 with end.
  - abort_err[3]=1; arbitration continues with source 0.
- out_grant held low for 50 cycles with source 0 requesting.
  - out_req stays 1 and src_grant stays 0; the watchdog does not run.
  - The transfer starts 1 cycle after out_grant rises.
- With DAQ_ARB_PRIO0_EN, sources 0 and 2 both request back-to-back.
  - Source 0 is granted every time; source 2 is granted only when source 0 is not requesting at IDLE.
